// File: rtl/result_hex_fmt.sv
// ----------------------------------------------------------------------------
// result_hex_fmt
//   Captures an ALU result on alu_done and streams it to the UART transmitter
//   as an ASCII hex line: optional '-', optional "0x", upper-case hex digits
//   with leading zeros suppressed, then CR LF (or LF only).
//   Each byte goes out over a registered valid/ready handshake.
//   A byte transfers on a tx_valid && tx_ready cycle. tx_valid then stays
//   low for one cycle while the next byte is loaded.
//
//   Build option: define HEX_PREFIX_EN to emit "0x" ahead of the digits.
//
// Ports
//   clk       in   system clock, rising edge
//   n_rst     in   asynchronous active-low reset
//   alu_done  in   1-cycle pulse, calc_res/format valid
//   calc_res  in   ALU result, DATA_W bits
//   format    in   0 = unsigned hex, 1 = signed two's complement
//   tx_ready  in   uart_tx accepts a byte this cycle
//   tx_valid  out  tx_data holds a byte to send
//   tx_data   out  ASCII byte
//   busy      out  line in progress
//   fmt_done  out  pulse the cycle after the final EOL byte is accepted
//   ovr_err   out  pulse when alu_done arrives while busy
//
// State   | meaning
// IDLE    | waiting for alu_done
// SIGN    | sending '-'
// PFX0    | sending '0' of the "0x" prefix (HEX_PREFIX_EN only)
// PFX1    | sending 'x' of the "0x" prefix (HEX_PREFIX_EN only)
// DIGIT   | sending nibble[idx], idx counts down to 0
// CR      | sending 0x0D (EOL_CRLF=1 only)
// LF      | sending 0x0A, last byte of the line
// ----------------------------------------------------------------------------
module result_hex_fmt #(
    parameter int DATA_W   = 32,
    parameter int EOL_CRLF = 1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] calc_res,
    input  logic              format,
    input  logic              tx_ready,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic              fmt_done,
    output logic              ovr_err
);

    localparam int NIB   = DATA_W / 4;
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SIGN,
`ifdef HEX_PREFIX_EN
        ST_PFX0,
        ST_PFX1,
`endif
        ST_DIGIT,
        ST_CR,
        ST_LF
    } state_t;

    // First state after the optional sign.
`ifdef HEX_PREFIX_EN
    localparam state_t ST_BODY = ST_PFX0;
`else
    localparam state_t ST_BODY = ST_DIGIT;
`endif
    localparam state_t ST_EOL = (EOL_CRLF != 0) ? ST_CR : ST_LF;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_mag;
    logic [DATA_W-1:0] w_mag_nxt;
    logic [DATA_W-1:0] w_mag_cap;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [IDX_W-1:0]  w_idx_cap;
    logic              w_neg_cap;
    logic              w_xfer;
    logic              w_valid_nxt;
    logic [3:0]        w_nib;
    logic [7:0]        w_byte_nxt;
    logic              r_tx_valid;
    logic [7:0]        r_tx_data;
    logic              r_fmt_done;
    logic              r_ovr_err;

    assign w_xfer = r_tx_valid & tx_ready;

    // Capture path: sign, magnitude and index of the leading nonzero nibble.
    // The most-negative value negates to itself, which is the right magnitude.
    always_comb begin
        w_neg_cap = format & calc_res[DATA_W-1];
        w_mag_cap = w_neg_cap ? (~calc_res + DATA_W'(1)) : calc_res;
        w_idx_cap = '0;
        for (int i = 0; i < NIB; i++) begin
            if (w_mag_cap[i*4 +: 4] != 4'd0) begin
                w_idx_cap = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mag_nxt   = r_mag;
        w_idx_nxt   = r_idx;
        case (r_state)
            ST_IDLE: begin
                if (alu_done) begin
                    w_mag_nxt   = w_mag_cap;
                    w_idx_nxt   = w_idx_cap;
                    w_state_nxt = w_neg_cap ? ST_SIGN : ST_BODY;
                end
            end
            ST_SIGN: begin
                if (w_xfer) w_state_nxt = ST_BODY;
            end
`ifdef HEX_PREFIX_EN
            ST_PFX0: begin
                if (w_xfer) w_state_nxt = ST_PFX1;
            end
            ST_PFX1: begin
                if (w_xfer) w_state_nxt = ST_DIGIT;
            end
`endif
            ST_DIGIT: begin
                if (w_xfer) begin
                    if (r_idx == '0) begin
                        w_state_nxt = ST_EOL;
                    end else begin
                        w_idx_nxt = r_idx - 1'b1;
                    end
                end
            end
            ST_CR: begin
                if (w_xfer) w_state_nxt = ST_LF;
            end
            ST_LF: begin
                if (w_xfer) begin
                    w_state_nxt = ST_IDLE;
                    w_mag_nxt   = '0;
                    w_idx_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Byte for the state being entered. While stalled, state/idx/mag are
    // unchanged, so tx_data holds steady without a separate hold path.
    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < NIB; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_nib = w_mag_nxt[i*4 +: 4];
            end
        end
        case (w_state_nxt)
            ST_SIGN:  w_byte_nxt = 8'h2D;
`ifdef HEX_PREFIX_EN
            ST_PFX0:  w_byte_nxt = 8'h30;
            ST_PFX1:  w_byte_nxt = 8'h78;
`endif
            ST_DIGIT: w_byte_nxt = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                                   : (8'h37 + {4'h0, w_nib});
            ST_CR:    w_byte_nxt = 8'h0D;
            ST_LF:    w_byte_nxt = 8'h0A;
            default:  w_byte_nxt = 8'h00;
        endcase
        // Dropping valid for the cycle after a transfer keeps tx_valid
        // purely registered and independent of tx_ready.
        w_valid_nxt = (w_state_nxt != ST_IDLE) && !w_xfer;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_mag      <= '0;
            r_idx      <= '0;
            r_tx_valid <= 1'b0;
            r_tx_data  <= 8'h00;
            r_fmt_done <= 1'b0;
            r_ovr_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mag      <= w_mag_nxt;
            r_idx      <= w_idx_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_data  <= w_byte_nxt;
            r_fmt_done <= w_xfer && (r_state == ST_LF);
            // The final LF cycle still counts as busy, so a result landing
            // there is dropped as well.
            r_ovr_err  <= alu_done && (r_state != ST_IDLE);
        end
    end

    assign tx_valid = r_tx_valid;
    assign tx_data  = r_tx_data;
    assign busy     = (r_state != ST_IDLE);
    assign fmt_done = r_fmt_done;
    assign ovr_err  = r_ovr_err;

endmodule

// File: tb/tb_result_hex_fmt.sv
// ----------------------------------------------------------------------------
// tb_result_hex_fmt
//   Random and directed results are formatted by result_hex_fmt. Expected
//   lines are built from the numeric value with divide/modulo arithmetic
//   and compared with the bytes accepted on the tx handshake.
// ----------------------------------------------------------------------------
module tb_result_hex_fmt;

    localparam int DATA_W   = 32;
    localparam int EOL_CRLF = 1;

    logic              clk = 1'b0;
    logic              n_rst = 1'b0;
    logic              alu_done = 1'b0;
    logic [DATA_W-1:0] calc_res = '0;
    logic              format = 1'b0;
    logic              tx_ready = 1'b0;
    logic              tx_valid;
    logic [7:0]        tx_data;
    logic              busy;
    logic              fmt_done;
    logic              ovr_err;

    result_hex_fmt #(.DATA_W(DATA_W), .EOL_CRLF(EOL_CRLF)) dut (
        .clk(clk), .n_rst(n_rst), .alu_done(alu_done), .calc_res(calc_res),
        .format(format), .tx_ready(tx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .busy(busy), .fmt_done(fmt_done), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    int        n_vec = 0;
    int        n_err = 0;
    int        cyc = 0;
    int        n_done = 0;
    int        n_ovr = 0;
    int        done_base = 0;
    int        last_xfer_cyc = 0;
    int        done_gap = 0;
    int        rdy_mode = 0;   // 0: always ready, 1: random, 2: held low
    bit        prev_stall = 0;
    logic [7:0] prev_data = 8'h00;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_vec++;
        if (got_v !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got_v, exp_v, cyc);
        end
    endtask

    // Reference line: sign, optional prefix, digits by repeated /16, EOL.
    task automatic build_exp(input logic [31:0] v, input bit f);
        bit          neg;
        logic [31:0] m;
        logic [7:0]  dq[$];
        int          d;
        neg = f && v[31];
        m   = neg ? (32'd0 - v) : v;
        exp_q.delete();
        if (neg) exp_q.push_back(8'h2D);
`ifdef HEX_PREFIX_EN
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
`endif
        do begin
            d = int'(m % 32'd16);
            dq.push_front((d < 10) ? 8'(48 + d) : 8'(65 + d - 10));
            m = m / 32'd16;
        end while (m != 0);
        foreach (dq[i]) exp_q.push_back(dq[i]);
        if (EOL_CRLF != 0) exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    always @(posedge clk) cyc++;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!n_rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_data", 32'(tx_data), 32'(prev_data));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            if (tx_valid && tx_ready) begin
                rx_q.push_back(tx_data);
                last_xfer_cyc = cyc;
            end
            if (fmt_done) begin
                n_done++;
                done_gap = cyc - last_xfer_cyc;
            end
            if (ovr_err) n_ovr++;
        end
    end

    // Called at posedge+#1; drives a capture pulse and checks the first byte.
    task automatic start_line(input logic [31:0] v, input bit f);
        build_exp(v, f);
        rx_q.delete();
        done_base = n_done;
        alu_done = 1'b1;
        calc_res = v;
        format   = f;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        calc_res = $urandom;
        format   = 1'($urandom_range(0, 1));
        chk("first_valid", 32'(tx_valid), 32'd1);
        chk("first_byte", 32'(tx_data), 32'(exp_q[0]));
    endtask

    task automatic finish_line(input string tag);
        bit ok = 0;
        for (int k = 0; k < 4000; k++) begin
            if (n_done > done_base) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk({tag, "_timeout"}, 32'(ok), 32'd1);
        chk({tag, "_done_gap"}, 32'(done_gap), 32'd1);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_line(input string tag, input logic [31:0] v, input bit f);
        start_line(v, f);
        finish_line(tag);
    endtask

    initial begin
        logic [31:0] v;
        bit          f;
        int          ovr_base;
        bit          seen;

        #12;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fmt_done", 32'(fmt_done), 32'd0);
        chk("rst_ovr_err", 32'(ovr_err), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        rdy_mode = 0;
        run_line("d1A2F", 32'h0000_1A2F, 1'b0);
        run_line("dm2", 32'hFFFF_FFFE, 1'b1);
        run_line("dFFFE_u", 32'hFFFF_FFFE, 1'b0);
        run_line("dzero", 32'h0000_0000, 1'b1);
        run_line("dmin", 32'h8000_0000, 1'b1);
        run_line("dm10", 32'hFFFF_FFF0, 1'b1);
        run_line("dpos_s", 32'h7FFF_FFFF, 1'b1);

        for (int n = 0; n < 40; n++) begin
            rdy_mode = int'($urandom_range(0, 1));
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) v = 32'd0;
            f = 1'($urandom_range(0, 1));
            run_line($sformatf("rnd%0d", n), v, f);
        end

        // Long stall mid-line.
        rdy_mode = 1;
        start_line(32'h89AB_CDEF, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 2;
        repeat (50) @(posedge clk);
        #2;
        chk("stall_valid", 32'(tx_valid), 32'd1);
        chk("stall_busy", 32'(busy), 32'd1);
        rdy_mode = 1;
        finish_line("stall");

        // Result arriving mid-line is dropped.
        rdy_mode = 1;
        ovr_base = n_ovr;
        start_line(32'h0000_BEEF, 1'b0);
        @(posedge clk);
        #1;
        alu_done = 1'b1;
        calc_res = 32'h1234_5678;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        chk("ovr_pulse", 32'(ovr_err), 32'd1);
        finish_line("ovr_mid");
        chk("ovr_count", 32'(n_ovr - ovr_base), 32'd1);

        // Result arriving on the final LF transfer is dropped too.
        rdy_mode = 0;
        start_line(32'h0000_00A5, 1'b1);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx_valid && tx_data == 8'h0A) begin
                seen = 1;
                break;
            end
        end
        chk("lf_seen", 32'(seen), 32'd1);
        alu_done = 1'b1;
        calc_res = 32'h0000_0077;
        @(posedge clk);
        #1;
        alu_done = 1'b0;
        chk("lf_ovr_pulse", 32'(ovr_err), 32'd1);
        chk("lf_fmt_done", 32'(fmt_done), 32'd1);
        @(posedge clk);
        #1;
        chk("lf_idle_busy", 32'(busy), 32'd0);
        chk("lf_idle_valid", 32'(tx_valid), 32'd0);
        finish_line("ovr_lf");

        // Reset mid-line, then a full line afterwards.
        rdy_mode = 1;
        start_line(32'hDEAD_BEEF, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        n_rst = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(tx_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        run_line("after_rst", 32'h0000_0C0D, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "global timeout");
    end

endmodule
